// File: rtl/alu_issue.sv
// alu_issue: decodes one operation per cycle from the decoder into the shared
// ALU operand/opcode format and hands it to the ALU through a 2-entry skid
// buffer. The output register holds the operation currently presented; the
// skid register catches one extra operation so that dec_ready can come from
// registered state alone.
module alu_issue #(
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dec_valid,
   output logic             dec_ready,
   input  logic [3:0]       op_class,
   input  logic [31:0]      rs_val,
   input  logic [31:0]      rt_val,
   input  logic [15:0]      imm,
   input  logic             use_imm,
   input  logic             imm_sign,
   input  logic [4:0]       shamt,
   input  logic [TAG_W-1:0] dec_tag,
   output logic             alu_valid,
   input  logic             alu_ready,
   output logic [31:0]      alu_in1,
   output logic [31:0]      alu_in2,
   output logic [2:0]       alu_op,
   output logic [4:0]       alu_shift,
   output logic [TAG_W-1:0] alu_tag,
   output logic             illegal,
   output logic [15:0]      issue_cnt
);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_ID  = 3'd5;
   localparam logic [2:0] OP_SLW = 3'd6;
   localparam logic [2:0] OP_SRW = 3'd7;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t           state;
   logic             accept;
   logic             consume;
   logic [31:0]      x_val;
   logic [31:0]      d_in1;
   logic [31:0]      d_in2;
   logic [2:0]       d_op;
   logic [4:0]       d_shift;
   logic             d_bad;
   logic [31:0]      skid_in1;
   logic [31:0]      skid_in2;
   logic [2:0]       skid_op;
   logic [4:0]       skid_shift;
   logic [TAG_W-1:0] skid_tag;

   assign accept  = dec_valid && dec_ready;
   assign consume = alu_valid && alu_ready;

   // Second operand: register rt or the immediate, sign- or zero-extended.
   assign x_val = use_imm ? (imm_sign ? {{16{imm[15]}}, imm} : {16'h0000, imm})
                          : rt_val;

   // Translate the decoder's operation class into ALU opcode and operands.
   // The ALU subtracts in1 from in2, so SUB swaps its operands.
   always_comb begin
      d_in1   = 32'd0;
      d_in2   = 32'd0;
      d_op    = OP_ID;
      d_shift = 5'd0;
      d_bad   = 1'b0;
      case (op_class)
         4'd0: begin d_op = OP_ADD; d_in1 = rs_val; d_in2 = x_val; end
         4'd1: begin d_op = OP_SUB; d_in1 = x_val;  d_in2 = rs_val; end
         4'd2: begin d_op = OP_AND; d_in1 = rs_val; d_in2 = x_val; end
         4'd3: begin d_op = OP_OR;  d_in1 = rs_val; d_in2 = x_val; end
         4'd4: begin d_op = OP_XOR; d_in1 = rs_val; d_in2 = x_val; end
         4'd5: begin d_op = OP_ID;  d_in2 = {imm, 16'h0000}; end
         4'd6: begin
            d_op    = OP_SLW;
            d_in1   = rt_val;
            d_shift = use_imm ? shamt : rs_val[4:0];
         end
         4'd7: begin
            d_op    = OP_SRW;
            d_in1   = rt_val;
            d_shift = use_imm ? shamt : rs_val[4:0];
         end
         4'd8: begin d_op = OP_ID; d_in2 = x_val; end
         default: d_bad = 1'b1;
      endcase
   end

   // Skid-buffer FSM: output register, skid register, handshakes and counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= EMPTY;
         dec_ready  <= 1'b1;
         alu_valid  <= 1'b0;
         illegal    <= 1'b0;
         issue_cnt  <= 16'd0;
         alu_in1    <= 32'd0;
         alu_in2    <= 32'd0;
         alu_op     <= 3'd0;
         alu_shift  <= 5'd0;
         alu_tag    <= '0;
         skid_in1   <= 32'd0;
         skid_in2   <= 32'd0;
         skid_op    <= 3'd0;
         skid_shift <= 5'd0;
         skid_tag   <= '0;
      end else begin
         illegal <= accept && d_bad;
         if (consume) begin
            issue_cnt <= issue_cnt + 16'd1;
         end
         case (state)
            EMPTY: begin
               if (accept) begin
                  alu_in1   <= d_in1;
                  alu_in2   <= d_in2;
                  alu_op    <= d_op;
                  alu_shift <= d_shift;
                  alu_tag   <= dec_tag;
                  alu_valid <= 1'b1;
                  state     <= ONE;
               end
            end
            ONE: begin
               if (accept && consume) begin
                  alu_in1   <= d_in1;
                  alu_in2   <= d_in2;
                  alu_op    <= d_op;
                  alu_shift <= d_shift;
                  alu_tag   <= dec_tag;
               end else if (accept) begin
                  skid_in1   <= d_in1;
                  skid_in2   <= d_in2;
                  skid_op    <= d_op;
                  skid_shift <= d_shift;
                  skid_tag   <= dec_tag;
                  dec_ready  <= 1'b0;
                  state      <= FULL;
               end else if (consume) begin
                  alu_valid <= 1'b0;
                  state     <= EMPTY;
               end
            end
            FULL: begin
               if (consume) begin
                  alu_in1   <= skid_in1;
                  alu_in2   <= skid_in2;
                  alu_op    <= skid_op;
                  alu_shift <= skid_shift;
                  alu_tag   <= skid_tag;
                  dec_ready <= 1'b1;
                  state     <= ONE;
               end
            end
            default: begin
               alu_valid <= 1'b0;
               dec_ready <= 1'b1;
               state     <= EMPTY;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed vectors for alu_issue. Stimulus pushes the
// hand-computed expected ALU operation into a scoreboard queue; a monitor
// pops and compares every time the DUT hands an operation to the ALU.
module tb_alu_issue;

   localparam int TAG_W = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             dec_valid;
   logic             dec_ready;
   logic [3:0]       op_class;
   logic [31:0]      rs_val;
   logic [31:0]      rt_val;
   logic [15:0]      imm;
   logic             use_imm;
   logic             imm_sign;
   logic [4:0]       shamt;
   logic [TAG_W-1:0] dec_tag;
   logic             alu_valid;
   logic             alu_ready;
   logic [31:0]      alu_in1;
   logic [31:0]      alu_in2;
   logic [2:0]       alu_op;
   logic [4:0]       alu_shift;
   logic [TAG_W-1:0] alu_tag;
   logic             illegal;
   logic [15:0]      issue_cnt;

   typedef struct packed {
      logic [2:0]       op;
      logic [31:0]      in1;
      logic [31:0]      in2;
      logic [4:0]       shift;
      logic [TAG_W-1:0] tag;
   } expOp_t;

   expOp_t      scoreboard[$];
   int          nCompared   = 0;
   int          nMismatched = 0;
   logic [15:0] expCnt      = 16'd0;

   alu_issue #(.TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .dec_valid (dec_valid),
      .dec_ready (dec_ready),
      .op_class  (op_class),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .imm       (imm),
      .use_imm   (use_imm),
      .imm_sign  (imm_sign),
      .shamt     (shamt),
      .dec_tag   (dec_tag),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_in1   (alu_in1),
      .alu_in2   (alu_in2),
      .alu_op    (alu_op),
      .alu_shift (alu_shift),
      .alu_tag   (alu_tag),
      .illegal   (illegal),
      .issue_cnt (issue_cnt)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Offer one operation (called just after a rising edge) and queue its expected result.
   task automatic applyStimulus(input logic [3:0] oc, input logic [31:0] rs,
                                input logic [31:0] rt, input logic [15:0] im,
                                input logic ui, input logic isg, input logic [4:0] sh,
                                input logic [TAG_W-1:0] tg, input logic [2:0] eOp,
                                input logic [31:0] eIn1, input logic [31:0] eIn2,
                                input logic [4:0] eShift);
      logic accepted;
      op_class  = oc;
      rs_val    = rs;
      rt_val    = rt;
      imm       = im;
      use_imm   = ui;
      imm_sign  = isg;
      shamt     = sh;
      dec_tag   = tg;
      dec_valid = 1'b1;
      scoreboard.push_back('{eOp, eIn1, eIn2, eShift, tg});
      accepted = 1'b0;
      for (int k = 0; k < 40 && !accepted; k++) begin
         @(negedge clk);
         accepted = dec_ready;
         @(posedge clk);
         #1;
      end
      dec_valid = 1'b0;
      checkOutput("accept_in_time", {31'd0, accepted}, 32'd1);
   endtask

   // Wait for the scoreboard to empty, then let the last consume take effect.
   task automatic waitDrain();
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         #1;
         if (scoreboard.size() == 0) break;
      end
      checkOutput("drain_in_time", scoreboard.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: checks each consumed op in order, and output stability while stalled.
   initial begin
      logic   stallPrev;
      expOp_t held;
      expOp_t e;
      stallPrev = 1'b0;
      held      = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            scoreboard.delete();
            expCnt    = 16'd0;
            stallPrev = 1'b0;
         end else begin
            if (stallPrev) begin
               checkOutput("hold_op",    {29'd0, alu_op},    {29'd0, held.op});
               checkOutput("hold_in1",   alu_in1,            held.in1);
               checkOutput("hold_in2",   alu_in2,            held.in2);
               checkOutput("hold_shift", {27'd0, alu_shift}, {27'd0, held.shift});
               checkOutput("hold_tag",   {27'd0, alu_tag},   {27'd0, held.tag});
            end
            if (alu_valid && alu_ready) begin
               if (scoreboard.size() == 0) begin
                  checkOutput("spurious_valid", {31'd0, alu_valid}, 32'd0);
               end else begin
                  e = scoreboard.pop_front();
                  checkOutput("tag",   {27'd0, alu_tag},   {27'd0, e.tag});
                  checkOutput("op",    {29'd0, alu_op},    {29'd0, e.op});
                  checkOutput("in1",   alu_in1,            e.in1);
                  checkOutput("in2",   alu_in2,            e.in2);
                  checkOutput("shift", {27'd0, alu_shift}, {27'd0, e.shift});
               end
               expCnt = expCnt + 16'd1;
            end
            stallPrev = alu_valid && !alu_ready;
            held      = '{alu_op, alu_in1, alu_in2, alu_shift, alu_tag};
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #1500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin
      int accepted;
      logic acc;
      rst       = 1'b1;
      dec_valid = 1'b0;
      alu_ready = 1'b1;
      op_class  = 4'd0;
      rs_val    = 32'd0;
      rt_val    = 32'd0;
      imm       = 16'd0;
      use_imm   = 1'b0;
      imm_sign  = 1'b0;
      shamt     = 5'd0;
      dec_tag   = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      @(negedge clk);
      checkOutput("rst_alu_valid", {31'd0, alu_valid}, 32'd0);
      checkOutput("rst_dec_ready", {31'd0, dec_ready}, 32'd1);
      checkOutput("rst_illegal",   {31'd0, illegal},   32'd0);
      checkOutput("rst_issue_cnt", {16'd0, issue_cnt}, 32'd0);
      checkOutput("rst_alu_in1",   alu_in1,            32'd0);
      checkOutput("rst_alu_in2",   alu_in2,            32'd0);
      checkOutput("rst_alu_op",    {29'd0, alu_op},    32'd0);
      checkOutput("rst_alu_shift", {27'd0, alu_shift}, 32'd0);
      checkOutput("rst_alu_tag",   {27'd0, alu_tag},   32'd0);
      @(posedge clk);
      #1;

      $display("[TB] directed decode vectors");
      // SUB rs=10, imm=3 signed: ALU computes in2 - in1
      applyStimulus(4'd1, 32'd10, 32'd99, 16'd3, 1'b1, 1'b1, 5'd0, 5'd1,
                    3'd1, 32'd3, 32'd10, 5'd0);
      @(negedge clk);
      checkOutput("latency_valid", {31'd0, alu_valid}, 32'd1);
      @(posedge clk);
      #1;
      applyStimulus(4'd0, 32'h1, 32'h0, 16'hFFFF, 1'b1, 1'b1, 5'd0, 5'd2,
                    3'd0, 32'h1, 32'hFFFFFFFF, 5'd0);
      applyStimulus(4'd0, 32'h1, 32'h0, 16'hFFFF, 1'b1, 1'b0, 5'd0, 5'd3,
                    3'd0, 32'h1, 32'h0000FFFF, 5'd0);
      applyStimulus(4'd7, 32'h24, 32'h80000000, 16'h0, 1'b0, 1'b0, 5'd9, 5'd4,
                    3'd7, 32'h80000000, 32'h0, 5'd4);
      applyStimulus(4'd6, 32'h3, 32'h1, 16'h0, 1'b1, 1'b0, 5'd31, 5'd5,
                    3'd6, 32'h1, 32'h0, 5'd31);
      applyStimulus(4'd5, 32'h5, 32'h6, 16'h1234, 1'b1, 1'b0, 5'd0, 5'd6,
                    3'd5, 32'h0, 32'h12340000, 5'd0);
      applyStimulus(4'd8, 32'h5, 32'hDEADBEEF, 16'h0, 1'b0, 1'b0, 5'd0, 5'd7,
                    3'd5, 32'h0, 32'hDEADBEEF, 5'd0);
      applyStimulus(4'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 16'h0, 1'b0, 1'b0, 5'd0, 5'd8,
                    3'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0);
      applyStimulus(4'd3, 32'h1, 32'h0, 16'h8000, 1'b1, 1'b0, 5'd0, 5'd9,
                    3'd3, 32'h1, 32'h00008000, 5'd0);
      applyStimulus(4'd4, 32'hAAAA5555, 32'h0, 16'h8001, 1'b1, 1'b1, 5'd0, 5'd10,
                    3'd4, 32'hAAAA5555, 32'hFFFF8001, 5'd0);
      // illegal class 12: identity of zero, tag kept, one-cycle pulse
      applyStimulus(4'd12, 32'h77, 32'h88, 16'h99, 1'b1, 1'b0, 5'd3, 5'd11,
                    3'd5, 32'h0, 32'h0, 5'd0);
      @(negedge clk);
      checkOutput("illegal_pulse", {31'd0, illegal}, 32'd1);
      @(negedge clk);
      checkOutput("illegal_clear", {31'd0, illegal}, 32'd0);
      @(posedge clk);
      #1;
      waitDrain();
      @(negedge clk);
      checkOutput("cnt_after_vectors", {16'd0, issue_cnt}, 32'd11);
      @(posedge clk);
      #1;

      $display("[TB] stall with three back-to-back offers");
      alu_ready = 1'b0;
      applyStimulus(4'd0, 32'd100, 32'd0, 16'd5, 1'b1, 1'b0, 5'd0, 5'd12,
                    3'd0, 32'd100, 32'd5, 5'd0);
      applyStimulus(4'd4, 32'hFF, 32'h0F, 16'd0, 1'b0, 1'b0, 5'd0, 5'd13,
                    3'd4, 32'hFF, 32'h0F, 5'd0);
      fork
         applyStimulus(4'd3, 32'h10, 32'h01, 16'd0, 1'b0, 1'b0, 5'd0, 5'd14,
                       3'd3, 32'h10, 32'h01, 5'd0);
         begin
            repeat (3) begin
               @(negedge clk);
               checkOutput("stall_dec_ready", {31'd0, dec_ready}, 32'd0);
               checkOutput("stall_head_tag",  {27'd0, alu_tag},   32'd12);
            end
            @(posedge clk);
            #1;
            alu_ready = 1'b1;
         end
      join
      waitDrain();
      @(negedge clk);
      checkOutput("cnt_after_stall", {16'd0, issue_cnt}, 32'd14);
      @(posedge clk);
      #1;

      $display("[TB] reset while full");
      alu_ready = 1'b0;
      applyStimulus(4'd8, 32'h0, 32'h55, 16'd0, 1'b0, 1'b0, 5'd0, 5'd15,
                    3'd5, 32'h0, 32'h55, 5'd0);
      applyStimulus(4'd1, 32'd7, 32'd2, 16'd0, 1'b0, 1'b0, 5'd0, 5'd16,
                    3'd1, 32'd2, 32'd7, 5'd0);
      @(negedge clk);
      checkOutput("full_dec_ready", {31'd0, dec_ready}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      alu_ready = 1'b1;
      @(negedge clk);
      checkOutput("rstfull_alu_valid", {31'd0, alu_valid}, 32'd0);
      checkOutput("rstfull_dec_ready", {31'd0, dec_ready}, 32'd1);
      checkOutput("rstfull_issue_cnt", {16'd0, issue_cnt}, 32'd0);
      repeat (5) @(negedge clk);
      checkOutput("rstfull_no_leftover", {31'd0, alu_valid}, 32'd0);
      @(posedge clk);
      #1;

      $display("[TB] counter wrap");
      accepted  = 0;
      dec_valid = 1'b1;
      for (int cyc = 0; cyc < 70000 && accepted < 65535; cyc++) begin
         op_class = 4'd8;
         rs_val   = ~accepted;
         rt_val   = accepted;
         imm      = 16'd0;
         use_imm  = 1'b0;
         imm_sign = 1'b0;
         shamt    = 5'd0;
         dec_tag  = accepted[TAG_W-1:0];
         @(negedge clk);
         acc = dec_ready;
         if (acc) begin
            scoreboard.push_back('{3'd5, 32'd0, accepted, 5'd0, accepted[TAG_W-1:0]});
         end
         @(posedge clk);
         #1;
         if (acc) accepted++;
      end
      dec_valid = 1'b0;
      checkOutput("bulk_accepts", accepted, 32'd65535);
      waitDrain();
      @(negedge clk);
      checkOutput("cnt_ffff", {16'd0, issue_cnt}, 32'h0000FFFF);
      @(posedge clk);
      #1;
      applyStimulus(4'd8, 32'h0, 32'h1234, 16'd0, 1'b0, 1'b0, 5'd0, 5'd3,
                    3'd5, 32'h0, 32'h1234, 5'd0);
      waitDrain();
      @(negedge clk);
      checkOutput("cnt_wrap", {16'd0, issue_cnt}, 32'd0);
      checkOutput("cnt_model", {16'd0, issue_cnt}, {16'd0, expCnt});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter TAG_W, default 5, width of the destination tag carried alongside each operation.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port dec_valid  input  1  decoder offers an operation this cycle.
REQ-005 SHALL have port dec_ready  output  1  issue stage accepts the offered operation this cycle.
REQ-006 SHALL have port op_class  input  4  operation class: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 LUI, 6 SLL, 7 SRL, 8 MOV; 9-15 illegal.
REQ-007 SHALL have ports rs_val, rt_val  input  32 each  register operands.
REQ-008 SHALL have ports imm  input  16, use_imm  input  1, imm_sign  input  1, shamt  input  5, dec_tag  input  TAG_W.
REQ-009 SHALL have port alu_valid  output  1  alu_in1/alu_in2/alu_op/alu_shift/alu_tag hold a valid operation.
REQ-010 SHALL have port alu_ready  input  1  consumer takes the presented operation.
REQ-011 SHALL have ports alu_in1, alu_in2  output  32, alu_op  output  3, alu_shift  output  5, alu_tag  output  TAG_W.
REQ-012 SHALL have port illegal  output  1  one-cycle pulse when an illegal op_class is accepted.
REQ-013 SHALL have port issue_cnt  output  16  count of operations handed to the ALU.

Function
REQ-014 SHALL drive alu_op with the shared ALU codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, ID 5, SLW 6, SRW 7.
REQ-015 SHALL form immediate operand X = use_imm ? (imm_sign ? sign-extend(imm) : zero-extend(imm)) : rt_val.
REQ-016 SHALL map ADD/AND/OR/XOR: in1 = rs_val, in2 = X, shift = 0.
REQ-017 SHALL map SUB (result rs - X) to ALU semantics out = in2 - in1: in2 = rs_val, in1 = X.
REQ-018 SHALL map LUI: op ID, in2 = {imm, 16'h0000}, in1 = 0, ignoring use_imm.
REQ-019 SHALL map MOV: op ID, in2 = X, in1 = 0.
REQ-020 SHALL map SLL/SRL: op SLW/SRW, in1 = rt_val, shift = use_imm ? shamt : rs_val[4:0], in2 = 0.
REQ-021 SHALL map illegal op_class to op ID, in1 = in2 = 0, shift = 0, tag passed through, and pulse illegal in the cycle after acceptance.
REQ-022 SHALL accept an operation when dec_valid && dec_ready and present an operation as consumed when alu_valid && alu_ready.
REQ-023 SHALL implement a 2-entry skid buffer: states EMPTY (0 entries), ONE (1), FULL (2).
REQ-024 SHALL assert dec_ready in EMPTY and ONE, deassert in FULL; dec_ready SHALL depend only on registered state.
REQ-025 SHALL register all alu_* outputs; latency from acceptance to alu_valid is exactly 1 cycle when EMPTY.
REQ-026 SHALL transition EMPTY->ONE on accept; ONE->EMPTY on consume without accept; ONE->FULL on accept without consume; ONE stays ONE on simultaneous accept and consume, loading the new op into the output register; FULL->ONE on consume, promoting the skid entry to the output register.
REQ-027 SHALL hold alu_* outputs stable while alu_valid && !alu_ready.
REQ-028 SHALL preserve strict acceptance order; no operation dropped or duplicated.
REQ-029 SHALL sustain one operation per cycle when alu_ready is held high.
REQ-030 SHALL increment issue_cnt by 1 per consume, wrapping 0xFFFF -> 0x0000.
REQ-031 SHALL ignore dec_valid when dec_ready is low and leave all decoder inputs unsampled.

Reset
REQ-032 SHALL on rst force state EMPTY, alu_valid 0, dec_ready 1 in the following cycle, illegal 0, issue_cnt 0, alu_in1/alu_in2/alu_op/alu_shift/alu_tag 0.
REQ-033 SHALL discard in-flight and buffered operations when rst is asserted mid-operation; acceptance and consumption in a reset cycle have no effect.

Verification
REQ-034 SHALL cover: SUB rs=10, imm=3 sign, use_imm=1 -> alu_op 1, alu_in2=10, alu_in1=3, alu_valid 1 cycle after accept.
REQ-035 SHALL cover: ADD rs=0x1, imm=0xFFFF, imm_sign=1 -> alu_in2=0xFFFFFFFF; imm_sign=0 -> alu_in2=0x0000FFFF.
REQ-036 SHALL cover: alu_ready=0 with three back-to-back offers -> first two accepted, dec_ready 0, third held; after alu_ready=1 outputs emerge in order, outputs stable while stalled.
REQ-037 SHALL cover: SRL rt=0x80000000, use_imm=0, rs_val=0x24 -> alu_op 7, alu_in1=0x80000000, alu_shift=4.
REQ-038 SHALL cover: op_class 12 accepted -> illegal pulses one cycle, alu_op 5, alu_in2=0; issue_cnt at 0xFFFF plus one consume -> 0x0000.
REQ-039 SHALL cover: rst asserted while FULL -> next cycle alu_valid 0, dec_ready 1, issue_cnt 0, no buffered op emerges afterwards.
